// File: rtl/ped_pkg.sv
// Shared types and helpers for the pedestrian crossing controller.
// Contents: FSM state encoding, light bit positions, one-hot legality check.
package ped_pkg;

   localparam int unsigned LIGHTS_W   = 3;
   localparam int unsigned RED_BIT    = 2;
   localparam int unsigned YELLOW_BIT = 1;
   localparam int unsigned GREEN_BIT  = 0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_WALK  = 3'd2,
      S_CLEAR = 3'd3,
      S_DONE  = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   // True when exactly one of red/yellow/green is lit.
   function automatic logic is_one_hot(input logic [LIGHTS_W-1:0] l);
      logic [1:0] cnt;
      cnt = 2'(l[RED_BIT]) + 2'(l[YELLOW_BIT]) + 2'(l[GREEN_BIT]);
      return (cnt == 2'd1);
   endfunction

endpackage

// File: rtl/ped_crossing_ctrl_timer.sv
// Loadable down counter shared by the walk and clearance phases.
// Ports: clk, reset (async, active-high), load/load_val (reload),
//        count (current value, saturates at 0), last (count == 1).
module ped_phase_timer #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             last
);

   // Free-running decrement; a load always wins, zero is sticky until reload.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign last = (count == CNT_W'(1));

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller fed by the traffic light FSM.
// Latches a request, serves it inside a fresh red phase as a steady walk
// interval plus a flashing clearance with countdown, aborts if red ends
// early, and locks into a fail-safe don't-walk state on illegal light codes.
// Ports: clk, reset (async, active-high), lights[2:0] (R/Y/G), ped_btn;
//        walk, dont_walk, wait_lamp, countdown, abort (pulse), fault (sticky).
module ped_crossing_ctrl
   import ped_pkg::*;
#(
   parameter int unsigned WALK_CYCLES  = 8,
   parameter int unsigned FLASH_CYCLES = 6,
   parameter int unsigned CNT_W        = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [LIGHTS_W-1:0] lights,
   input  logic                ped_btn,
   output logic                walk,
   output logic                dont_walk,
   output logic                wait_lamp,
   output logic [CNT_W-1:0]    countdown,
   output logic                abort,
   output logic                fault
);

   state_t           state;
   logic             pending;
   logic             red_q;

   logic             legal_c;
   logic             abort_c;
   logic             normal_c;
   logic             red_rise_c;
   logic             pend_set_c;
   logic             tmr_load_c;
   logic [CNT_W-1:0] tmr_load_val_c;
   logic [CNT_W-1:0] tmr_count;
   logic             tmr_last;

   assign legal_c    = is_one_hot(lights);
   assign red_rise_c = lights[RED_BIT] & ~red_q;
   assign abort_c    = legal_c && !lights[RED_BIT] &&
                       ((state == S_WALK) || (state == S_CLEAR));
   assign normal_c   = legal_c && !abort_c && (state != S_FAULT);
   assign pend_set_c = pending | ped_btn;

   // Timer reloads on entry to WALK and on the WALK->CLEAR hand-off.
   assign tmr_load_c = normal_c &&
                       (((state == S_ARMED) && red_rise_c) ||
                        ((state == S_WALK)  && tmr_last));
   assign tmr_load_val_c = (state == S_ARMED) ? CNT_W'(WALK_CYCLES)
                                              : CNT_W'(FLASH_CYCLES);

   ped_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load_c),
      .load_val (tmr_load_val_c),
      .count    (tmr_count),
      .last     (tmr_last)
   );

   // Controller FSM with registered lamp outputs; fault > abort > normal.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         walk      <= 1'b0;
         dont_walk <= 1'b1;
         wait_lamp <= 1'b0;
         countdown <= '0;
         abort     <= 1'b0;
         fault     <= 1'b0;
         pending   <= 1'b0;
         red_q     <= 1'b0;
      end else begin
         red_q <= lights[RED_BIT];
         abort <= 1'b0;
         if (state == S_FAULT) begin
            state <= S_FAULT;
         end else if (!legal_c) begin
            state     <= S_FAULT;
            fault     <= 1'b1;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            wait_lamp <= 1'b0;
            pending   <= 1'b0;
            countdown <= '0;
         end else if (abort_c) begin
            // Interrupted service stays owed; re-arm for the next red rise.
            state     <= S_ARMED;
            pending   <= 1'b1;
            wait_lamp <= 1'b1;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            countdown <= '0;
            abort     <= 1'b1;
         end else begin
            pending   <= pend_set_c;
            wait_lamp <= pend_set_c;
            case (state)
               S_IDLE: begin
                  walk      <= 1'b0;
                  dont_walk <= 1'b1;
                  if (pend_set_c) state <= S_ARMED;
               end
               S_ARMED: begin
                  // Only a fresh red edge starts service, never red already on.
                  if (red_rise_c) begin
                     state     <= S_WALK;
                     pending   <= 1'b0;
                     wait_lamp <= 1'b0;
                     walk      <= 1'b1;
                     dont_walk <= 1'b0;
                  end
               end
               S_WALK: begin
                  if (tmr_last) begin
                     state     <= S_CLEAR;
                     walk      <= 1'b0;
                     dont_walk <= 1'b1;
                     countdown <= CNT_W'(FLASH_CYCLES);
                  end
               end
               S_CLEAR: begin
                  if (tmr_last) begin
                     state     <= S_DONE;
                     dont_walk <= 1'b1;
                     countdown <= '0;
                  end else begin
                     dont_walk <= ~dont_walk;
                     countdown <= tmr_count - CNT_W'(1);
                  end
               end
               S_DONE: begin
                  dont_walk <= 1'b1;
                  if (!lights[RED_BIT]) state <= S_IDLE;
               end
               S_FAULT: begin
                  state <= S_FAULT;
               end
               default: begin
                  state     <= S_FAULT;
                  fault     <= 1'b1;
                  walk      <= 1'b0;
                  dont_walk <= 1'b1;
                  wait_lamp <= 1'b0;
                  pending   <= 1'b0;
                  countdown <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Self-checking bench for ped_crossing_ctrl (default parameters).
// Table of {lights, ped_btn, expected outputs} vectors plus hand sequences
// for illegal lights and asynchronous reset.
module tb_ped_crossing_ctrl;

   localparam int unsigned FLASH = 6;
   localparam logic [2:0]  G = 3'b001;
   localparam logic [2:0]  Y = 3'b010;
   localparam logic [2:0]  R = 3'b100;
   // {walk, dont_walk, wait_lamp, countdown[3:0], abort, fault}
   localparam logic [8:0]  RST_VAL = 9'b0_1_0_0000_0_0;
   localparam logic [8:0]  FLT_VAL = 9'b0_1_0_0000_0_1;
   localparam logic [8:0]  WALK_VAL = 9'b1_0_0_0000_0_0;

   typedef struct packed {
      logic [2:0] lights;
      logic       btn;
      logic [8:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] lights = G;
   logic       ped_btn = 1'b0;
   logic       walk, dont_walk, wait_lamp, abort, fault;
   logic [3:0] countdown;

   int passed = 0;
   int total  = 0;
   vec_t vecs[$];

   ped_crossing_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .lights    (lights),
      .ped_btn   (ped_btn),
      .walk      (walk),
      .dont_walk (dont_walk),
      .wait_lamp (wait_lamp),
      .countdown (countdown),
      .abort     (abort),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] outs();
      return {walk, dont_walk, wait_lamp, countdown, abort, fault};
   endfunction

   task automatic check(input string name, input logic [8:0] want);
      logic [8:0] got;
      got = outs();
      total++;
      if (got === want) passed++;
      else $display("FAIL %s: got w/dw/wl/cd/ab/f=%b want %b", name, got, want);
   endtask

   task automatic step(input logic [2:0] l, input logic b);
      lights  = l;
      ped_btn = b;
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic [2:0] l, input logic b,
                               input logic w, input logic dw, input logic wl,
                               input logic [3:0] cd, input logic ab, input logic f);
      vec_t v;
      v.lights = l;
      v.btn    = b;
      v.exp    = {w, dw, wl, cd, ab, f};
      vecs.push_back(v);
   endfunction

   function automatic void add_walk(input int n);
      for (int k = 0; k < n; k++) add(R, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
   endfunction

   // Six clearance cycles; optional button press on clearance cycle btn_k.
   function automatic void add_clear(input int btn_k);
      for (int k = 1; k <= int'(FLASH); k++)
         add(R, (k == btn_k), 1'b0, (k % 2 == 1), (btn_k != 0 && k >= btn_k),
             4'(int'(FLASH) + 1 - k), 1'b0, 1'b0);
   endfunction

   initial begin
      // Basic service: request in green, served from the next red rise.
      add(G, 1, 0, 1, 1, 0, 0, 0);
      add(G, 0, 0, 1, 1, 0, 0, 0);
      add(Y, 0, 0, 1, 1, 0, 0, 0);
      add(R, 0, 1, 0, 0, 0, 0, 0);
      add_walk(7);
      add_clear(0);
      add(R, 0, 0, 1, 0, 0, 0, 0);
      add(R, 0, 0, 1, 0, 0, 0, 0);
      add(G, 0, 0, 1, 0, 0, 0, 0);
      add(G, 0, 0, 1, 0, 0, 0, 0);
      // Late request while red already on: waits through this red.
      add(Y, 0, 0, 1, 0, 0, 0, 0);
      add(R, 0, 0, 1, 0, 0, 0, 0);
      add(R, 1, 0, 1, 1, 0, 0, 0);
      add(R, 0, 0, 1, 1, 0, 0, 0);
      add(R, 0, 0, 1, 1, 0, 0, 0);
      add(G, 0, 0, 1, 1, 0, 0, 0);
      add(Y, 0, 0, 1, 1, 0, 0, 0);
      add(R, 0, 1, 0, 0, 0, 0, 0);
      // Short red: drops during walk cycle 3 -> abort, re-armed.
      add(R, 0, 1, 0, 0, 0, 0, 0);
      add(R, 0, 1, 0, 0, 0, 0, 0);
      add(G, 0, 0, 1, 1, 0, 1, 0);
      add(G, 0, 0, 1, 1, 0, 0, 0);
      add(Y, 0, 0, 1, 1, 0, 0, 0);
      add(R, 0, 1, 0, 0, 0, 0, 0);
      add_walk(7);
      // Request during clearance -> second service on the following red.
      add_clear(3);
      add(R, 0, 0, 1, 1, 0, 0, 0);
      add(G, 0, 0, 1, 1, 0, 0, 0);
      add(G, 0, 0, 1, 1, 0, 0, 0);
      add(Y, 0, 0, 1, 1, 0, 0, 0);
      add(R, 0, 1, 0, 0, 0, 0, 0);
      add_walk(7);
      add_clear(0);
      add(R, 0, 0, 1, 0, 0, 0, 0);
      add(G, 0, 0, 1, 0, 0, 0, 0);
      add(G, 0, 0, 1, 0, 0, 0, 0);

      // Reset state, checked before any clock edge.
      #2 reset = 1'b1;
      #1 check("reset_state", RST_VAL);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].lights, vecs[i].btn);
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Illegal lights in the middle of a walk; sticky until reset.
      step(G, 1); step(Y, 0); step(R, 0);
      check("flt_pre_walk", WALK_VAL);
      step(3'b110, 0); check("flt_110", FLT_VAL);
      step(3'b000, 0); check("flt_000", FLT_VAL);
      step(G, 1);      check("flt_stuck_g_btn", FLT_VAL);
      step(Y, 0);      check("flt_stuck_y", FLT_VAL);
      step(R, 0);      check("flt_stuck_r", FLT_VAL);
      lights = G;
      reset  = 1'b1;
      #1 check("flt_reset", RST_VAL);
      #2 reset = 1'b0;
      step(G, 0); check("flt_post_reset_idle", RST_VAL);

      // Async reset between edges during WALK.
      step(G, 1); step(Y, 0); step(R, 0); step(R, 0);
      check("ar_walk_pre", WALK_VAL);
      #3 reset = 1'b1;
      #1 check("ar_walk_async", RST_VAL);
      lights = G;
      #2 reset = 1'b0;
      step(G, 0); check("ar_walk_post_idle", RST_VAL);

      // Async reset during CLEAR with a nonzero countdown.
      step(G, 1); step(Y, 0); step(R, 0);
      for (int k = 0; k < 7; k++) step(R, 0);
      step(R, 0); step(R, 0);
      check("ar_clear_pre", 9'b0_0_0_0101_0_0);
      #3 reset = 1'b1;
      #1 check("ar_clear_async", RST_VAL);
      lights = G;
      #2 reset = 1'b0;
      step(G, 0); check("ar_clear_post_idle", RST_VAL);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ped_crossing_ctrl.md
# ped_crossing_ctrl

Pedestrian crossing controller that sits directly downstream of the traffic light FSM and consumes its 3-bit `lights` bus. A pedestrian request is latched and served only inside a fresh red phase. Service is a fixed walk interval followed by a flashing don't-walk clearance with a visible countdown. Illegal light codes are caught, and the block falls back to a fail-safe don't-walk state.

## Interface
Parameters:
- `WALK_CYCLES`, default 8: length of the steady walk interval in clocks; legal range 1..2^CNT_W-1.
- `FLASH_CYCLES`, default 6: length of the flashing clearance in clocks; legal range 1..2^CNT_W-1.
- `CNT_W`, default 4: width of the phase timer and of `countdown`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `lights` in 3: from the traffic FSM; bit 2 red, bit 1 yellow, bit 0 green. Synchronous to `clk`.
- `ped_btn` in 1: synchronous pedestrian request, level or pulse.
- `walk` out 1: walk lamp.
- `dont_walk` out 1: don't-walk lamp (steady or flashing).
- `wait_lamp` out 1: request-acknowledged indicator.
- `countdown` out CNT_W: remaining clearance cycles; 0 outside CLEAR.
- `abort` out 1: one-cycle pulse when red ends during service.
- `fault` out 1: sticky illegal-lights flag.

## Operation
States: IDLE, ARMED, WALK, CLEAR, DONE, FAULT. All outputs are registered.
- Reset values: state IDLE, `walk`=0, `dont_walk`=1, `wait_lamp`=0, `countdown`=0, `abort`=0, `fault`=0, pending=0, red_q=0.
- `red_rise` = `lights`[2] & ~red_q, where red_q is `lights`[2] registered.
- Pending request: set by `ped_btn`=1 in any non-FAULT state; cleared on entry to WALK. `wait_lamp` = pending.
- IDLE: if pending or `ped_btn`, go to ARMED. Outputs: `dont_walk`=1.
- ARMED: wait for `red_rise`; then go to WALK and load the timer with WALK_CYCLES. A request arriving while red is already on waits for the next red rise.
- WALK: `walk`=1, `dont_walk`=0, for exactly WALK_CYCLES cycles. Then go to CLEAR and load FLASH_CYCLES.
- CLEAR: `walk`=0.
  - `dont_walk` is 1 on the first CLEAR cycle and toggles every cycle after that.
  - `countdown` shows FLASH_CYCLES on the first cycle and decrements to 1 on the last.
  - Then go to DONE.
- DONE: `dont_walk`=1 steady. Stay until `lights`[2]=0, then go to IDLE. A request pending at that point goes on to ARMED the following cycle.
- Abort: `lights`[2]=0 sampled in WALK or CLEAR.
  - Next cycle: state ARMED, pending=1, `walk`=0, `dont_walk`=1, `countdown`=0, `abort`=1 for one cycle.
- Fault: `lights` not exactly one-hot (000, or two or more bits set), sampled in any state.
  - Next cycle: state FAULT, `fault`=1, `walk`=0, `dont_walk`=1 steady, `wait_lamp`=0, `countdown`=0.
  - Leaves FAULT only on `reset`.
- Priority (highest first): fault > abort > normal transition. `ped_btn` in the same cycle as an abort or fault is absorbed: it is kept as pending on abort and ignored on fault.

## Timing
- `ped_btn` sampled high in IDLE: ARMED and `wait_lamp`=1 on the next edge.
- Red rise sampled in ARMED: `walk`=1 on the next edge, 1-cycle latency.
- The walk interval is WALK_CYCLES clocks. It is followed immediately by FLASH_CYCLES clearance clocks, with no gap cycle.
- Reset asserted mid-service: all outputs return to their reset values immediately, without waiting for a clock.
- The timer wraps never. It saturates at 0, and its load value is always at least 1.

## Structure
- Package `ped_pkg`: state enum; light bit index constants RED_BIT=2, YELLOW_BIT=1, GREEN_BIT=0; one-hot legality function.
- Sub-module `ped_phase_timer`: a CNT_W-bit loadable down counter.
  - Inputs: `load`, `load_val`.
  - Outputs: `count`, `last` (count==1).
  - The FSM instantiates one of these and shares it between WALK and CLEAR.

## Test plan
- Basic service: drive green→yellow→red; pulse `ped_btn` during green.
  - `wait_lamp`=1 next cycle.
  - `walk`=1 exactly one cycle after red rises, for 8 cycles.
  - Then 6 flash cycles with `dont_walk` 1,0,1,0,1,0 and `countdown` 6..1.
  - Then `dont_walk` steady until red drops.
- Late request: `ped_btn` while red is already on → no walk in that red phase; service starts in the next red.
- Short red: red drops on walk cycle 3 → `abort` pulses once, `walk`=0, state ARMED; full service in the following red.
- Request during service: `ped_btn` during CLEAR → `wait_lamp`=1. After red ends, a second full service follows on the next red rise.
- Illegal lights: drive 3'b110, then 3'b000 → `fault`=1 and `dont_walk`=1 from the next edge. Outputs stay stuck through later valid codes until `reset`.
- Async reset during WALK: assert `reset` between edges → `walk`=0, `dont_walk`=1 and `countdown`=0 immediately.
